full_subtractor_core: RTL and testbench

Registered ripple-borrow full subtractor. Computes a − b − bin over WIDTH bits and produces a difference and a borrow-out. The default WIDTH=1 is the classic 1-bit full subtractor cell. Outputs are registered once with a valid flag, so the block drops into pipelined datapaths such as ALU slices and decrementers.

---
 rtl/full_subtractor_core.sv | 57 +++++
 tb/tb_full_subtractor_core.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/full_subtractor_core.sv
// Registered ripple-borrow full subtractor: {bout, diff} = a - b - bin over WIDTH bits.
// The result is registered once and tagged with out_valid; diff/bout hold while in_valid is low.
module full_subtractor_core #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             out_valid
);

    logic [WIDTH-1:0] w_diff;
    logic             w_bout;
    logic [WIDTH:0]   w_borrow;

    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_valid;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_diff      = '0;
        w_borrow    = '0;
        w_borrow[0] = bin;
        for (int i = 0; i < WIDTH; i++) begin
            w_diff[i]       = a[i] ^ b[i] ^ w_borrow[i];
            w_borrow[i + 1] = (~a[i] & b[i]) | (~a[i] & w_borrow[i]) | (b[i] & w_borrow[i]);
        end
        w_bout = w_borrow[WIDTH];
    end

    // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            // Idle cycles leave the last result visible for downstream consumers.
            if (in_valid) begin
                r_diff <= w_diff;
                r_bout <= w_bout;
            end
        end
    end

    assign diff      = r_diff;
    assign bout      = r_bout;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_full_subtractor_core.sv
// Self-checking bench for full_subtractor_core at WIDTH = 1, 4 and 8.
// Directed vector table, hold/reset sequences, then random vectors against an arithmetic model.
module tb_full_subtractor_core;

    logic clk = 1'b0;
    logic rst_n;

    logic       v1, a1, b1, bin1, d1, bo1, ov1;
    logic       v4, bin4, bo4, ov4;
    logic [3:0] a4, b4, d4;
    logic       v8, bin8, bo8, ov8;
    logic [7:0] a8, b8, d8;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         w;
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
    } vec_t;

    vec_t vecs[12];

    full_subtractor_core #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .bin(bin1),
        .diff(d1), .bout(bo1), .out_valid(ov1)
    );
    full_subtractor_core #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .bin(bin4),
        .diff(d4), .bout(bo4), .out_valid(ov4)
    );
    full_subtractor_core #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .bin(bin8),
        .diff(d8), .bout(bo8), .out_valid(ov8)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(int w, logic [7:0] a, logic [7:0] b, logic bin,
                                logic [7:0] diff, logic bout);
        vec_t v;
        v.w = w; v.a = a; v.b = b; v.bin = bin; v.diff = diff; v.bout = bout;
        return v;
    endfunction

    initial begin
        logic [8:0] exp9;
        logic [7:0] m_diff;
        logic       m_bout;
        logic       m_valid;
        int         r;

        // Expected values taken directly from the subtractor truth table and worked examples.
        vecs[0]  = mk(1, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 1, 1, 1);
        vecs[2]  = mk(1, 0, 1, 0, 1, 1);
        vecs[3]  = mk(1, 0, 1, 1, 0, 1);
        vecs[4]  = mk(1, 1, 0, 0, 1, 0);
        vecs[5]  = mk(1, 1, 0, 1, 0, 0);
        vecs[6]  = mk(1, 1, 1, 0, 0, 0);
        vecs[7]  = mk(1, 1, 1, 1, 1, 1);
        vecs[8]  = mk(4, 3, 5, 0, 8'he, 1);
        vecs[9]  = mk(4, 9, 4, 1, 8'h4, 0);
        vecs[10] = mk(4, 0, 15, 1, 8'h0, 1);
        vecs[11] = mk(4, 15, 0, 0, 8'hf, 0);

        rst_n = 1'b0;
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; bin1 = 1'b0;
        v4 = 1'b1; a4 = 4'd1; b4 = 4'd0; bin4 = 1'b0;
        v8 = 1'b1; a8 = 8'd1; b8 = 8'd0; bin8 = 1'b0;

        // Reset held two cycles with valid operands present: outputs must stay cleared.
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_w1", {ov1, bo1, d1}, 32'h0);
            check("rst_w4", {ov4, bo4, d4}, 32'h0);
            check("rst_w8", {ov8, bo8, d8}, 32'h0);
        end
        rst_n = 1'b1;
        tick();
        check("post_rst_w1", {ov1, bo1, d1}, {29'h0, 1'b1, 1'b0, 1'b1});
        check("post_rst_w8", {ov8, bo8, d8}, {22'h0, 1'b1, 1'b0, 8'h01});
        v1 = 1'b0; v4 = 1'b0; v8 = 1'b0;
        tick();
        check("idle_valid_w1", {31'h0, ov1}, 32'h0);

        // Table vectors, applied back-to-back on their own instance.
        for (int i = 0; i < 12; i++) begin
            v1 = (vecs[i].w == 1);
            v4 = (vecs[i].w == 4);
            a1 = vecs[i].a[0]; b1 = vecs[i].b[0]; bin1 = vecs[i].bin;
            a4 = vecs[i].a[3:0]; b4 = vecs[i].b[3:0]; bin4 = vecs[i].bin;
            tick();
            if (vecs[i].w == 1)
                check($sformatf("vec%0d_w1", i), {ov1, bo1, 7'h0, d1},
                      {1'b1, vecs[i].bout, vecs[i].diff});
            else
                check($sformatf("vec%0d_w4", i), {ov4, bo4, 4'h0, d4},
                      {1'b1, vecs[i].bout, vecs[i].diff});
        end

        // Hold: last W4 result was 15 - 0 - 0 = 15, no borrow.
        v1 = 1'b0; v4 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            a4 = 4'(c * 5 + 2); b4 = 4'(c * 3 + 7); bin4 = c[0];
            tick();
            check($sformatf("hold%0d_w4", c), {ov4, bo4, d4}, {26'h0, 1'b0, 1'b0, 4'hf});
        end

        // Mid-stream reset discards the in-flight result; first valid afterwards is normal.
        v8 = 1'b1; a8 = 8'd10; b8 = 8'd3; bin8 = 1'b0;
        tick();
        check("pre_midrst_w8", {ov8, bo8, d8}, {22'h0, 1'b1, 1'b0, 8'd7});
        a8 = 8'd20; b8 = 8'd30; bin8 = 1'b1;
        rst_n = 1'b0;
        tick();
        check("midrst_w8", {ov8, bo8, d8}, 32'h0);
        rst_n = 1'b1;
        tick();
        check("after_midrst_w8", {ov8, bo8, d8}, {22'h0, 1'b1, 1'b1, 8'(20 - 30 - 1)});

        // Random vectors at WIDTH=8 against signed-integer arithmetic with a hold model.
        m_diff = d8; m_bout = bo8;
        for (int i = 0; i < 1000; i++) begin
            v8   = ($urandom_range(0, 9) < 8);
            a8   = 8'($urandom_range(0, 255));
            b8   = 8'($urandom_range(0, 255));
            bin8 = 1'($urandom_range(0, 1));
            if (i % 50 == 0) begin
                a8 = (i % 100 == 0) ? 8'h00 : 8'hff;
                b8 = (i % 100 == 0) ? 8'hff : 8'h00;
                bin8 = (i % 100 == 0);
            end
            r = int'(a8) - int'(b8) - int'(bin8);
            exp9 = 9'(r);
            m_valid = v8;
            if (v8) begin
                m_diff = exp9[7:0];
                m_bout = (r < 0);
            end
            tick();
            check($sformatf("rand%0d_w8", i), {ov8, bo8, d8}, {22'h0, m_valid, m_bout, m_diff});
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
